alu_operand_arbiter: RTL and testbench

Round-robin arbiter that shares the 32-bit 8:1 operand select path between eight requesters. Each cycle it picks one pending requester, drives the 3-bit mux select, and captures the selected word into a registered output stage. It hands that word to the downstream ALU stage with a valid/ready handshake. It sits between the requester register files and the ALU operand input, and it owns the select lines of the 8:1 operand mux.

---
 rtl/alu_operand_arbiter_if.sv | 25 ++
 rtl/alu_operand_arbiter.sv | 85 ++++++++
 tb/tb_alu_operand_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_arbiter_if.sv
// Operand-path bundle between the requester register files, the arbiter and the ALU stage.
// Handshake: out_data transfers downstream on a rising edge where out_valid and out_ready are both 1; once raised, out_valid and out_data stay stable until that transfer.
interface alu_operand_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 8
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data_in;
  logic [NREQ-1:0]       grant;
  logic [2:0]            sel;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;

  modport master (
    input  req, data_in, out_ready,
    output grant, sel, out_data, out_valid, busy
  );

  modport slave (
    output req, data_in, out_ready,
    input  grant, sel, out_data, out_valid, busy
  );
endinterface

// File: rtl/alu_operand_arbiter.sv
// Round-robin owner of the 8:1 operand mux select; captures the winning requester's word
// into a registered output stage that is handed to the ALU with valid/ready.
module alu_operand_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  alu_operand_arbiter_if.master bus,
  output logic                  dbg_state,
  output logic [2:0]            dbg_ptr
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [2:0]        sel_q, sel_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [WIDTH-1:0]  data_q, data_d;

  logic              found;
  logic [2:0]        win_idx;
  logic [2:0]        scan_idx;
  logic              capture;

  // Scan starting at ptr; the first pending index wins, so at most one winner exists.
  always_comb begin
    found    = 1'b0;
    win_idx  = 3'd0;
    scan_idx = 3'd0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = ptr_q + 3'(k);
      if (!found && bus.req[scan_idx]) begin
        found   = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  // A new word may enter only when the stage is empty or is draining this edge.
  assign capture = found && ((state_q == IDLE) || bus.out_ready);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    grant_d = '0;
    if (capture) begin
      state_d = HOLD;
      ptr_d   = win_idx + 3'd1;
      sel_d   = win_idx;
      data_d  = bus.data_in[int'(win_idx)*WIDTH +: WIDTH];
      grant_d = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
    end else if (state_q == HOLD && bus.out_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      sel_q   <= 3'd0;
      grant_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      data_q  <= data_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.sel       = sel_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.busy      = (state_q == HOLD);
  assign dbg_state     = (state_q == HOLD);
  assign dbg_ptr       = ptr_q;

endmodule

// File: tb/tb_alu_operand_arbiter.sv
// Directed-vector bench for alu_operand_arbiter: reset, single capture, round robin,
// stall under out_ready=0, pointer priority and asynchronous reset mid-hold.
module tb_alu_operand_arbiter;

  logic       clock;
  logic       reset_n;
  logic       dbg_state;
  logic [2:0] dbg_ptr;
  int         vec_cnt;
  int         err_cnt;

  alu_operand_arbiter_if #(.WIDTH(32), .NREQ(8)) bus ();

  alu_operand_arbiter #(.WIDTH(32), .NREQ(8)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_slice(input int idx, input logic [31:0] val);
    bus.data_in[idx*32 +: 32] = val;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n       = 1'b0;
    bus.req       = 8'h00;
    bus.data_in   = '0;
    bus.out_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vec_cnt++;
    if (bus.grant !== 8'h00 || bus.sel !== 3'd0 || bus.out_data !== 32'h0 ||
        bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || dbg_state !== 1'b0 || dbg_ptr !== 3'd0) begin
      err_cnt++;
      $display("FAIL reset: grant=%h sel=%0d data=%h valid=%b busy=%b st=%b ptr=%0d, expected all zero",
               bus.grant, bus.sel, bus.out_data, bus.out_valid, bus.busy, dbg_state, dbg_ptr);
    end
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clock);
    bus.req       = 8'b0000_0100;
    set_slice(2, 32'hDEAD_BEEF);
    bus.out_ready = 1'b1;
    step();
    vec_cnt++;
    if (bus.grant !== 8'h04 || bus.sel !== 3'd2 || bus.out_data !== 32'hDEAD_BEEF || bus.out_valid !== 1'b1) begin
      err_cnt++;
      $display("FAIL single_capture: grant=%h sel=%0d data=%h valid=%b, expected 04 2 deadbeef 1",
               bus.grant, bus.sel, bus.out_data, bus.out_valid);
    end
    @(negedge clock);
    bus.req = 8'h00;
    step();
    vec_cnt++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.grant !== 8'h00 ||
        bus.sel !== 3'd2 || bus.out_data !== 32'hDEAD_BEEF) begin
      err_cnt++;
      $display("FAIL single_drain: valid=%b busy=%b grant=%h sel=%0d data=%h, expected 0 0 00 2 deadbeef",
               bus.out_valid, bus.busy, bus.grant, bus.sel, bus.out_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_g;
    do_reset();
    @(negedge clock);
    for (int i = 0; i < 8; i++) set_slice(i, 32'(i));
    bus.req       = 8'hFF;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 9; n++) begin
      step();
      exp_g = 8'h01 << (n % 8);
      vec_cnt++;
      if (bus.grant !== exp_g || bus.out_data !== 32'(n % 8) || bus.sel !== 3'(n % 8) || bus.out_valid !== 1'b1) begin
        err_cnt++;
        $display("FAIL rr_cycle%0d: grant=%h data=%h sel=%0d valid=%b, expected %h %h %0d 1",
                 n, bus.grant, bus.out_data, bus.sel, bus.out_valid, exp_g, 32'(n % 8), n % 8);
      end
    end
    @(negedge clock);
    bus.req = 8'h00;
    step();
  endtask

  task automatic test_stall();
    do_reset();
    @(negedge clock);
    bus.req       = 8'h20;
    set_slice(5, 32'h5555_0005);
    bus.out_ready = 1'b0;
    step();
    vec_cnt++;
    if (bus.grant !== 8'h20 || bus.sel !== 3'd5 || bus.out_data !== 32'h5555_0005) begin
      err_cnt++;
      $display("FAIL stall_capture: grant=%h sel=%0d data=%h, expected 20 5 55550005",
               bus.grant, bus.sel, bus.out_data);
    end
    @(negedge clock);
    bus.req = 8'h21;
    set_slice(0, 32'h0000_AAAA);
    for (int n = 0; n < 4; n++) begin
      step();
      vec_cnt++;
      if (bus.grant !== 8'h00 || bus.sel !== 3'd5 || bus.out_data !== 32'h5555_0005 || bus.out_valid !== 1'b1) begin
        err_cnt++;
        $display("FAIL stall_hold%0d: grant=%h sel=%0d data=%h valid=%b, expected 00 5 55550005 1",
                 n, bus.grant, bus.sel, bus.out_data, bus.out_valid);
      end
    end
    @(negedge clock);
    bus.out_ready = 1'b1;
    step();
    vec_cnt++;
    if (bus.grant !== 8'h01 || bus.sel !== 3'd0 || bus.out_data !== 32'h0000_AAAA || bus.out_valid !== 1'b1) begin
      err_cnt++;
      $display("FAIL stall_release: grant=%h sel=%0d data=%h valid=%b, expected 01 0 0000aaaa 1",
               bus.grant, bus.sel, bus.out_data, bus.out_valid);
    end
    @(negedge clock);
    bus.req = 8'h00;
    step();
    vec_cnt++;
    if (bus.out_valid !== 1'b0 || bus.grant !== 8'h00) begin
      err_cnt++;
      $display("FAIL stall_drain: valid=%b grant=%h, expected 0 00", bus.out_valid, bus.grant);
    end
  endtask

  task automatic test_ptr_priority();
    do_reset();
    @(negedge clock);
    bus.req       = 8'h04;
    bus.out_ready = 1'b1;
    step();
    @(negedge clock);
    bus.req = 8'b1000_0010;
    set_slice(7, 32'h7777_0007);
    set_slice(1, 32'h1111_0001);
    step();
    vec_cnt++;
    if (bus.grant !== 8'h80 || bus.sel !== 3'd7 || bus.out_data !== 32'h7777_0007) begin
      err_cnt++;
      $display("FAIL ptr3_first: grant=%h sel=%0d data=%h, expected 80 7 77770007",
               bus.grant, bus.sel, bus.out_data);
    end
    step();
    vec_cnt++;
    if (bus.grant !== 8'h02 || bus.sel !== 3'd1 || bus.out_data !== 32'h1111_0001) begin
      err_cnt++;
      $display("FAIL ptr_wrap_second: grant=%h sel=%0d data=%h, expected 02 1 11110001",
               bus.grant, bus.sel, bus.out_data);
    end
    step();
    vec_cnt++;
    if (bus.grant !== 8'h80 || bus.sel !== 3'd7) begin
      err_cnt++;
      $display("FAIL ptr2_third: grant=%h sel=%0d, expected 80 7", bus.grant, bus.sel);
    end
    @(negedge clock);
    bus.req = 8'h00;
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clock);
    bus.req       = 8'h01;
    set_slice(0, 32'hCAFE_0000);
    bus.out_ready = 1'b0;
    step();
    @(negedge clock);
    bus.req = 8'h00;
    step();
    vec_cnt++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hCAFE_0000 || bus.grant !== 8'h00) begin
      err_cnt++;
      $display("FAIL areset_pre: valid=%b data=%h grant=%h, expected 1 cafe0000 00",
               bus.out_valid, bus.out_data, bus.grant);
    end
    #1;
    reset_n = 1'b0;
    #1;
    vec_cnt++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_data !== 32'h0 ||
        bus.sel !== 3'd0 || bus.grant !== 8'h00) begin
      err_cnt++;
      $display("FAIL areset_immediate: valid=%b busy=%b data=%h sel=%0d grant=%h, expected all zero",
               bus.out_valid, bus.busy, bus.out_data, bus.sel, bus.grant);
    end
    @(negedge clock);
    bus.req       = 8'h01;
    bus.out_ready = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    vec_cnt++;
    if (bus.out_valid !== 1'b0 || bus.grant !== 8'h00) begin
      err_cnt++;
      $display("FAIL areset_release: valid=%b grant=%h, expected 0 00 before first edge",
               bus.out_valid, bus.grant);
    end
    step();
    vec_cnt++;
    if (bus.grant !== 8'h01 || bus.sel !== 3'd0 || bus.out_data !== 32'hCAFE_0000 || bus.out_valid !== 1'b1) begin
      err_cnt++;
      $display("FAIL areset_first_grant: grant=%h sel=%0d data=%h valid=%b, expected 01 0 cafe0000 1",
               bus.grant, bus.sel, bus.out_data, bus.out_valid);
    end
  endtask

  initial begin
    vec_cnt       = 0;
    err_cnt       = 0;
    reset_n       = 1'b0;
    bus.req       = 8'h00;
    bus.data_in   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_ptr_priority();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
